// File: rtl/px_fill_engine_pkg.sv
// Shared pixel-plane constants and fill-engine state encoding.
package fsx_pkg;

  localparam int PX_H_RES  = 320;
  localparam int PX_V_RES  = 240;
  localparam int PX_ADDR_W = 17;
  localparam int PX_DATA_W = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } pxfill_state_t;

endpackage

// File: rtl/px_fill_engine_if.sv
// Command / VRAM-write bundle between the CPU-side requester and px_fill_engine.
interface px_fill_engine_if;
  import fsx_pkg::*;

  logic                 start;
  logic [8:0]           x;
  logic [7:0]           y;
  logic [8:0]           w;
  logic [7:0]           h;
  logic [PX_DATA_W-1:0] color;
  logic                 busy;
  logic                 done;
  logic                 vramPX_we;
  logic [PX_ADDR_W-1:0] vramPX_addr;
  logic [PX_DATA_W-1:0] vramPX_d;
  logic                 wr_gnt;

  modport master (
    output start, x, y, w, h, color, wr_gnt,
    input  busy, done, vramPX_we, vramPX_addr, vramPX_d
  );

  modport slave (
    input  start, x, y, w, h, color, wr_gnt,
    output busy, done, vramPX_we, vramPX_addr, vramPX_d
  );

endinterface

// File: rtl/px_fill_engine_clip.sv
// Combinational rectangle extent / clip / row-base logic for px_fill_engine.
// CLIP_EN=0 drops the min() stage and passes the raw sums through.
module pxfill_clip
  import fsx_pkg::*;
#(
  parameter int H_RES   = PX_H_RES,
  parameter int V_RES   = PX_V_RES,
  parameter bit CLIP_EN = 1'b1
) (
  input  logic [8:0]           x_i,
  input  logic [7:0]           y_i,
  input  logic [8:0]           w_i,
  input  logic [7:0]           h_i,
  output logic [9:0]           x1_o,
  output logic [8:0]           y1_o,
  output logic [PX_ADDR_W-1:0] rowbase_o,
  output logic                 empty_o
);

  logic [9:0] sx;
  logic [8:0] sy;

  always_comb begin
    // One extra bit on each sum so the extents can never wrap.
    sx   = {1'b0, x_i} + {1'b0, w_i};
    sy   = {1'b0, y_i} + {1'b0, h_i};
    x1_o = sx;
    y1_o = sy;
    if (CLIP_EN) begin
      if (sx > 10'(H_RES)) x1_o = 10'(H_RES);
      if (sy > 9'(V_RES))  y1_o = 9'(V_RES);
    end
    // Covers w/h == 0 and, when clipping, origins already off the plane.
    empty_o   = (x1_o <= {1'b0, x_i}) || (y1_o <= {1'b0, y_i});
    // y*320 as shift-add; the row stride is fixed by the plane layout.
    rowbase_o = ({9'd0, y_i} << 8) + ({9'd0, y_i} << 6);
  end

endmodule

// File: rtl/px_fill_engine.sv
// Rectangle-fill engine: writes a clipped colour rectangle into pixel VRAM,
// one pixel per granted cycle. Define PXFILL_CLIP_EN to enable plane clipping.
module px_fill_engine
  import fsx_pkg::*;
#(
  parameter int H_RES = PX_H_RES,
  parameter int V_RES = PX_V_RES
) (
  input logic              clk,
  input logic              resetn,
  px_fill_engine_if.slave  bus
);

`ifdef PXFILL_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  pxfill_state_t        state_q, state_d;
  logic [8:0]           x_q, x_d;
  logic [7:0]           y_q, y_d;
  logic [8:0]           w_q, w_d;
  logic [7:0]           h_q, h_d;
  logic [PX_DATA_W-1:0] color_q, color_d;
  logic [9:0]           x1_q, x1_d;
  logic [8:0]           y1_q, y1_d;
  logic [9:0]           col_q, col_d;
  logic [8:0]           row_q, row_d;
  logic [PX_ADDR_W-1:0] rowbase_q, rowbase_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 we_q, we_d;
  logic [PX_ADDR_W-1:0] addr_q, addr_d;
  logic [PX_DATA_W-1:0] d_q, d_d;

  logic [9:0]           c_x1;
  logic [8:0]           c_y1;
  logic [PX_ADDR_W-1:0] c_rowbase;
  logic                 c_empty;

  pxfill_clip #(
    .H_RES   (H_RES),
    .V_RES   (V_RES),
    .CLIP_EN (CLIP_EN)
  ) u_clip (
    .x_i       (x_q),
    .y_i       (y_q),
    .w_i       (w_q),
    .h_i       (h_q),
    .x1_o      (c_x1),
    .y1_o      (c_y1),
    .rowbase_o (c_rowbase),
    .empty_o   (c_empty)
  );

  logic last_col, last_row;
  assign last_col = (col_q == x1_q - 10'd1);
  assign last_row = (row_q == y1_q - 9'd1);

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    w_d       = w_q;
    h_d       = h_q;
    color_d   = color_q;
    x1_d      = x1_q;
    y1_d      = y1_q;
    col_d     = col_q;
    row_d     = row_q;
    rowbase_d = rowbase_q;
    busy_d    = busy_q;
    done_d    = done_q;
    we_d      = we_q;
    addr_d    = addr_q;
    d_d       = d_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          x_d     = bus.x;
          y_d     = bus.y;
          w_d     = bus.w;
          h_d     = bus.h;
          color_d = bus.color;
          busy_d  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        x1_d      = c_x1;
        y1_d      = c_y1;
        col_d     = {1'b0, x_q};
        row_d     = {1'b0, y_q};
        rowbase_d = c_rowbase;
        d_d       = color_q;
        if (c_empty) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end else begin
          we_d    = 1'b1;
          addr_d  = c_rowbase + 17'(x_q);
          state_d = WRITE;
        end
      end
      WRITE: begin
        // Without a grant every register holds, so the request stays stable.
        if (bus.wr_gnt) begin
          if (last_col && last_row) begin
            we_d    = 1'b0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end else if (last_col) begin
            col_d     = {1'b0, x_q};
            row_d     = row_q + 9'd1;
            rowbase_d = rowbase_q + 17'(H_RES);
            addr_d    = rowbase_q + 17'(H_RES) + 17'(x_q);
          end else begin
            col_d  = col_q + 10'd1;
            addr_d = rowbase_q + 17'(col_q) + 17'd1;
          end
        end
      end
      DONE: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      color_q   <= '0;
      x1_q      <= '0;
      y1_q      <= '0;
      col_q     <= '0;
      row_q     <= '0;
      rowbase_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      d_q       <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      w_q       <= w_d;
      h_q       <= h_d;
      color_q   <= color_d;
      x1_q      <= x1_d;
      y1_q      <= y1_d;
      col_q     <= col_d;
      row_q     <= row_d;
      rowbase_q <= rowbase_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      d_q       <= d_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.vramPX_we   = we_q;
  assign bus.vramPX_addr = addr_q;
  assign bus.vramPX_d    = d_q;

endmodule
